time_set_ctrl: RTL and testbench
================================

Name: time_set_ctrl

Overview:
Front-panel time-setting controller for the HH:MM:SS clock. It debounces the MODE and INC push-buttons and walks the user through the hour, minute and second fields. It then issues a one-cycle load pulse carrying the new BCD time and the AM/PM flag to the clock counter. It sits between the board buttons and the counter's load port, on the same divided clock as the counter, and drives a blink enable for the digit being edited.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive identical synchronized samples needed to accept a new button level (minimum 2)
BLINK_DIV, 12500000, clock cycles per o_blink half-period

Ports:
i_clk  input  1  clock; all logic is on the rising edge
i_rst  input  1  asynchronous active-high reset
i_btn_mode  input  1  raw MODE button, active-high, asynchronous to i_clk
i_btn_inc  input  1  raw INC button, active-high, asynchronous to i_clk
i_cur_hh  input  8  current hours from the clock, BCD {tens,units}, 01..12
i_cur_mm  input  8  current minutes, BCD 00..59
i_cur_ss  input  8  current seconds, BCD 00..59
i_cur_pm  input  1  current PM flag
o_load  output  1  one-cycle pulse; the clock loads o_hh/o_mm/o_ss/o_pm on this pulse
o_hh  output  8  edited hours, BCD
o_mm  output  8  edited minutes, BCD
o_ss  output  8  edited seconds, BCD
o_pm  output  1  edited PM flag
o_setting  output  1  high while in any SET state
o_field  output  2  0=none, 1=hours, 2=minutes, 3=seconds
o_blink  output  1  blink enable for the display of the field in o_field

Behaviour:
- Reset values (asynchronous, i_rst high):
  - FSM in RUN.
  - o_load=0, o_hh=8'h12, o_mm=8'h00, o_ss=8'h00, o_pm=0.
  - o_setting=0, o_field=0, o_blink=0.
  - Synchronizers, debounce counters and the blink counter are cleared.
  - Debounced button levels are 0.
- Button input path, per button:
  - 2-FF synchronizer.
  - The debounce counter increments while the synchronized level differs from the accepted level and clears when they match.
  - When the count reaches DEBOUNCE_CYCLES, the accepted level takes the synchronized level and the counter clears.
  - A 0->1 transition of the accepted level produces a one-cycle press pulse.
  - Latency from a clean raw edge to the press pulse is DEBOUNCE_CYCLES+3 cycles.
  - A held button produces exactly one pulse.
- FSM states: RUN, SET_HH, SET_MM, SET_SS, COMMIT.
  - RUN + mode press: capture i_cur_* into the shadow registers (o_hh/o_mm/o_ss/o_pm), then go to SET_HH.
    - If the captured hours are not valid BCD 01..12, o_hh is set to 8'h12.
    - If the captured minutes or seconds are not valid BCD 00..59, that field is set to 8'h00.
  - SET_HH -> SET_MM -> SET_SS on each mode press.
  - SET_SS + mode press -> COMMIT.
  - COMMIT lasts exactly 1 cycle with o_load=1, then returns to RUN.
  - INC press in RUN or COMMIT is ignored.
- INC press in each SET state:
  - SET_HH: hours increment 01..12. 12 wraps to 01. 11->12 toggles o_pm.
  - SET_MM: minutes increment with BCD carry, 09->10 and 59->00. No carry into hours.
  - SET_SS: seconds are cleared to 00, regardless of the current value.
- Simultaneous press pulses in the same cycle: mode wins and the inc pulse is dropped.
- Shadow outputs hold their value in RUN. They are not tracked from i_cur_* until the next capture.
- o_setting is 1 in SET_HH, SET_MM and SET_SS; it is 0 in RUN and COMMIT.
- o_field is 1/2/3 in SET_HH/SET_MM/SET_SS and 0 otherwise.
- Blink:
  - Free-running counter that toggles an internal phase every BLINK_DIV cycles.
  - o_blink = phase AND o_setting.
  - The counter restarts at the entry to SET_HH, so the first half-period begins with o_blink=1.
- Reset mid-edit: the FSM returns to RUN, no o_load pulse is issued, and the shadow registers return to their reset values.

Test Plan (DEBOUNCE_CYCLES=4, BLINK_DIV=8):
- Reset, then idle for 100 cycles -> o_hh=12, o_mm=00, o_ss=00, o_pm=0, o_load never asserted.
- Set i_cur=11:59:37 AM. Press MODE, press INC once, then press MODE three times -> o_field goes 1,2,3,0. Exactly one o_load pulse, carrying 12:59:37 with o_pm=1.
- Enter SET_MM with minutes at 58. Press INC twice -> 59 then 00, hours unchanged. In SET_SS, press INC -> ss=00.
- Feed a 3-cycle glitch followed by 6-cycle bounce pulses, then a 20-cycle hold on MODE -> exactly one press pulse, arriving 7 cycles after the stable edge.
- Press MODE and INC in the same cycle while in SET_HH -> advance to SET_MM, hours unchanged.
- Assert i_rst while in SET_MM after edits -> immediate RUN, o_setting=0, o_blink=0, no o_load, o_hh=12.

Source files
------------

// File: rtl/time_set_ctrl_if.sv
// Button, current-time and load/display bundle between the front panel and the
// time-setting controller. The controller takes the slave side.
interface time_set_ctrl_if;
  logic       i_btn_mode;
  logic       i_btn_inc;
  logic [7:0] i_cur_hh;
  logic [7:0] i_cur_mm;
  logic [7:0] i_cur_ss;
  logic       i_cur_pm;
  logic       o_load;
  logic [7:0] o_hh;
  logic [7:0] o_mm;
  logic [7:0] o_ss;
  logic       o_pm;
  logic       o_setting;
  logic [1:0] o_field;
  logic       o_blink;

  modport master (
    output i_btn_mode, i_btn_inc, i_cur_hh, i_cur_mm, i_cur_ss, i_cur_pm,
    input  o_load, o_hh, o_mm, o_ss, o_pm, o_setting, o_field, o_blink
  );

  modport slave (
    input  i_btn_mode, i_btn_inc, i_cur_hh, i_cur_mm, i_cur_ss, i_cur_pm,
    output o_load, o_hh, o_mm, o_ss, o_pm, o_setting, o_field, o_blink
  );
endinterface

// File: rtl/time_set_ctrl.sv
// Front-panel HH:MM:SS time-setting controller: debounced MODE/INC buttons walk
// the hour, minute and second fields, then issue a one-cycle load to the clock.
module time_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int BLINK_DIV       = 12500000
) (
  input  logic           i_clk,
  input  logic           i_rst,
  time_set_ctrl_if.slave bus
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BL_W = $clog2(BLINK_DIV + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_DIV - 1);

  typedef enum logic [2:0] {RUN, SET_HH, SET_MM, SET_SS, COMMIT} state_t;

  // Bit 0 = MODE, bit 1 = INC
  logic [1:0] btn_raw;
  logic [1:0] press;

  assign btn_raw = {bus.i_btn_inc, bus.i_btn_mode};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic            sync1_reg;
      logic            sync2_reg;
      logic            level_reg;
      logic            level_d_reg;
      logic            press_reg;
      logic [DB_W-1:0] cnt_reg;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          sync1_reg   <= 1'b0;
          sync2_reg   <= 1'b0;
          level_reg   <= 1'b0;
          level_d_reg <= 1'b0;
          press_reg   <= 1'b0;
          cnt_reg     <= '0;
        end else begin
          sync1_reg   <= btn_raw[gi];
          sync2_reg   <= sync1_reg;
          level_d_reg <= level_reg;
          press_reg   <= level_reg & ~level_d_reg;
          if (sync2_reg == level_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DB_LAST) begin
            // This edge completes the run of identical differing samples
            level_reg <= sync2_reg;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign press[gi] = press_reg;
    end
  endgenerate

  logic mode_press;
  logic inc_press;

  assign mode_press = press[0];
  // Mode wins over a coincident inc pulse
  assign inc_press  = press[1] & ~press[0];

  function automatic logic hh_valid(input logic [7:0] v);
    return ((v[7:4] == 4'd0) && (v[3:0] >= 4'd1) && (v[3:0] <= 4'd9)) ||
           ((v[7:4] == 4'd1) && (v[3:0] <= 4'd2));
  endfunction

  function automatic logic sixty_valid(input logic [7:0] v);
    return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
  endfunction

  function automatic logic [7:0] hh_inc(input logic [7:0] v);
    if (v == 8'h12)        return 8'h01;
    else if (v == 8'h09)   return 8'h10;
    else                   return v + 8'h01;
  endfunction

  function automatic logic [7:0] sixty_inc(input logic [7:0] v);
    if (v == 8'h59)             return 8'h00;
    else if (v[3:0] == 4'd9)    return {v[7:4] + 4'd1, 4'd0};
    else                        return v + 8'h01;
  endfunction

  state_t     state_reg, state_next;
  logic [7:0] hh_reg, hh_next;
  logic [7:0] mm_reg, mm_next;
  logic [7:0] ss_reg, ss_next;
  logic       pm_reg, pm_next;
  logic       enter_hh;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= RUN;
      hh_reg    <= 8'h12;
      mm_reg    <= 8'h00;
      ss_reg    <= 8'h00;
      pm_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      hh_reg    <= hh_next;
      mm_reg    <= mm_next;
      ss_reg    <= ss_next;
      pm_reg    <= pm_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    hh_next    = hh_reg;
    mm_next    = mm_reg;
    ss_next    = ss_reg;
    pm_next    = pm_reg;
    enter_hh   = 1'b0;
    case (state_reg)
      RUN: begin
        if (mode_press) begin
          state_next = SET_HH;
          enter_hh   = 1'b1;
          hh_next    = hh_valid(bus.i_cur_hh)    ? bus.i_cur_hh : 8'h12;
          mm_next    = sixty_valid(bus.i_cur_mm) ? bus.i_cur_mm : 8'h00;
          ss_next    = sixty_valid(bus.i_cur_ss) ? bus.i_cur_ss : 8'h00;
          pm_next    = bus.i_cur_pm;
        end
      end
      SET_HH: begin
        if (mode_press) begin
          state_next = SET_MM;
        end else if (inc_press) begin
          hh_next = hh_inc(hh_reg);
          if (hh_reg == 8'h11) pm_next = ~pm_reg;
        end
      end
      SET_MM: begin
        if (mode_press)     state_next = SET_SS;
        else if (inc_press) mm_next = sixty_inc(mm_reg);
      end
      SET_SS: begin
        if (mode_press)     state_next = COMMIT;
        else if (inc_press) ss_next = 8'h00;
      end
      COMMIT:  state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  logic [BL_W-1:0] blink_cnt_reg;
  logic            phase_reg;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b0;
    end else if (enter_hh) begin
      // Restart so the edited digit is visible for a full first half-period
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b1;
    end else if (blink_cnt_reg == BL_LAST) begin
      blink_cnt_reg <= '0;
      phase_reg     <= ~phase_reg;
    end else begin
      blink_cnt_reg <= blink_cnt_reg + 1'b1;
    end
  end

  logic       setting;
  logic [1:0] field;

  always_comb begin
    setting = 1'b0;
    field   = 2'd0;
    case (state_reg)
      SET_HH: begin setting = 1'b1; field = 2'd1; end
      SET_MM: begin setting = 1'b1; field = 2'd2; end
      SET_SS: begin setting = 1'b1; field = 2'd3; end
      default: begin setting = 1'b0; field = 2'd0; end
    endcase
  end

  assign bus.o_load    = (state_reg == COMMIT);
  assign bus.o_hh      = hh_reg;
  assign bus.o_mm      = mm_reg;
  assign bus.o_ss      = ss_reg;
  assign bus.o_pm      = pm_reg;
  assign bus.o_setting = setting;
  assign bus.o_field   = field;
  assign bus.o_blink   = phase_reg & setting;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: table-driven edit sessions with a load
// scoreboard, plus debounce, blink, simultaneous-press and mid-edit reset cases.
module tb_time_set_ctrl;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;

  time_set_ctrl_if bus();

  time_set_ctrl #(.DEBOUNCE_CYCLES(4), .BLINK_DIV(8)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0] hh, mm, ss;
    logic       pm;
  } load_t;

  typedef struct {
    logic [7:0] cur_hh, cur_mm, cur_ss;
    logic       cur_pm;
    int         n_hh, n_mm;
    bit         clr_ss;
    logic [7:0] e_hh, e_mm, e_ss;
    logic       e_pm;
  } vec_t;

  int    checks     = 0;
  int    failures   = 0;
  int    load_count = 0;
  load_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // Scoreboard: each o_load pulse must match the oldest pushed expectation
  always @(negedge i_clk) begin
    if (!i_rst && bus.o_load) begin
      load_count++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL load_unexpected actual=%h:%h:%h pm=%b expected=none",
                 bus.o_hh, bus.o_mm, bus.o_ss, bus.o_pm);
      end else begin
        load_t e;
        e = exp_q.pop_front();
        if ({bus.o_hh, bus.o_mm, bus.o_ss, bus.o_pm} !== {e.hh, e.mm, e.ss, e.pm}) begin
          failures++;
          $display("FAIL load_payload actual=%h:%h:%h pm=%b expected=%h:%h:%h pm=%b",
                   bus.o_hh, bus.o_mm, bus.o_ss, bus.o_pm, e.hh, e.mm, e.ss, e.pm);
        end else begin
          $display("ok   load %h:%h:%h pm=%b", bus.o_hh, bus.o_mm, bus.o_ss, bus.o_pm);
        end
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic press_mode();
    bus.i_btn_mode = 1'b1;
    repeat (10) tick();
    bus.i_btn_mode = 1'b0;
    repeat (10) tick();
  endtask

  task automatic press_inc();
    bus.i_btn_inc = 1'b1;
    repeat (10) tick();
    bus.i_btn_inc = 1'b0;
    repeat (10) tick();
  endtask

  task automatic set_cur(input logic [7:0] h, input logic [7:0] m,
                         input logic [7:0] s, input logic p);
    bus.i_cur_hh = h;
    bus.i_cur_mm = m;
    bus.i_cur_ss = s;
    bus.i_cur_pm = p;
  endtask

  vec_t       vecs[6];
  logic [7:0] prev_hh;
  int         loads_before;

  initial begin
    vecs[0] = '{8'h11, 8'h59, 8'h37, 1'b0, 1, 0, 1'b0, 8'h12, 8'h59, 8'h37, 1'b1};
    vecs[1] = '{8'h03, 8'h58, 8'h20, 1'b1, 0, 2, 1'b0, 8'h03, 8'h00, 8'h20, 1'b1};
    vecs[2] = '{8'h13, 8'h7A, 8'h60, 1'b0, 0, 0, 1'b0, 8'h12, 8'h00, 8'h00, 1'b0};
    vecs[3] = '{8'h12, 8'h09, 8'h05, 1'b0, 1, 1, 1'b0, 8'h01, 8'h10, 8'h05, 1'b0};
    vecs[4] = '{8'h09, 8'h45, 8'h59, 1'b1, 3, 0, 1'b1, 8'h12, 8'h45, 8'h00, 1'b0};
    vecs[5] = '{8'h00, 8'h30, 8'h59, 1'b1, 2, 0, 1'b0, 8'h02, 8'h30, 8'h59, 1'b1};

    bus.i_btn_mode = 1'b0;
    bus.i_btn_inc  = 1'b0;
    set_cur(8'h00, 8'h00, 8'h00, 1'b0);

    // Reset state
    repeat (3) tick();
    chk("rst_hh", bus.o_hh, 8'h12);
    chk("rst_mm", bus.o_mm, 8'h00);
    chk("rst_ss", bus.o_ss, 8'h00);
    chk("rst_pm", bus.o_pm, 1'b0);
    chk("rst_load", bus.o_load, 1'b0);
    chk("rst_setting", bus.o_setting, 1'b0);
    chk("rst_field", bus.o_field, 2'd0);
    chk("rst_blink", bus.o_blink, 1'b0);
    i_rst = 1'b0;

    repeat (100) tick();
    chk("idle_hh", bus.o_hh, 8'h12);
    chk("idle_mm", bus.o_mm, 8'h00);
    chk("idle_ss", bus.o_ss, 8'h00);
    chk("idle_pm", bus.o_pm, 1'b0);
    chk("idle_no_load", load_count, 0);

    // Table-driven edit sessions
    prev_hh = 8'h12;
    for (int i = 0; i < 6; i++) begin
      set_cur(vecs[i].cur_hh, vecs[i].cur_mm, vecs[i].cur_ss, vecs[i].cur_pm);
      press_inc();
      chk($sformatf("v%0d_run_inc_ignored", i), bus.o_hh, prev_hh);
      chk($sformatf("v%0d_run_field", i), bus.o_field, 2'd0);
      loads_before = load_count;
      exp_q.push_back('{vecs[i].e_hh, vecs[i].e_mm, vecs[i].e_ss, vecs[i].e_pm});
      press_mode();
      chk($sformatf("v%0d_field_hh", i), bus.o_field, 2'd1);
      for (int k = 0; k < vecs[i].n_hh; k++) press_inc();
      press_mode();
      chk($sformatf("v%0d_field_mm", i), bus.o_field, 2'd2);
      for (int k = 0; k < vecs[i].n_mm; k++) press_inc();
      press_mode();
      chk($sformatf("v%0d_field_ss", i), bus.o_field, 2'd3);
      chk($sformatf("v%0d_setting", i), bus.o_setting, 1'b1);
      if (vecs[i].clr_ss) press_inc();
      press_mode();
      chk($sformatf("v%0d_field_done", i), bus.o_field, 2'd0);
      chk($sformatf("v%0d_setting_done", i), bus.o_setting, 1'b0);
      chk($sformatf("v%0d_one_load", i), load_count, loads_before + 1);
      set_cur(8'h07, 8'h07, 8'h07, ~vecs[i].e_pm);
      repeat (5) tick();
      chk($sformatf("v%0d_hold_hh", i), bus.o_hh, vecs[i].e_hh);
      chk($sformatf("v%0d_hold_mm", i), bus.o_mm, vecs[i].e_mm);
      chk($sformatf("v%0d_hold_ss", i), bus.o_ss, vecs[i].e_ss);
      chk($sformatf("v%0d_hold_pm", i), bus.o_pm, vecs[i].e_pm);
      prev_hh = vecs[i].e_hh;
    end

    // Minute carry 58 -> 59 -> 00 with no carry into hours; seconds clear
    set_cur(8'h05, 8'h58, 8'h10, 1'b0);
    press_mode();
    press_mode();
    press_inc();
    chk("mm_58_to_59", bus.o_mm, 8'h59);
    press_inc();
    chk("mm_59_to_00", bus.o_mm, 8'h00);
    chk("mm_no_hh_carry", bus.o_hh, 8'h05);
    press_mode();
    press_inc();
    chk("ss_cleared", bus.o_ss, 8'h00);
    exp_q.push_back('{8'h05, 8'h00, 8'h00, 1'b0});
    press_mode();

    // Debounce: glitch and bounces must not register, then one clean press
    set_cur(8'h07, 8'h15, 8'h30, 1'b1);
    repeat (5) tick();
    bus.i_btn_mode = 1'b1;
    repeat (3) tick();
    bus.i_btn_mode = 1'b0;
    repeat (6) tick();
    repeat (4) begin
      bus.i_btn_mode = 1'b1;
      repeat (3) tick();
      bus.i_btn_mode = 1'b0;
      repeat (3) tick();
    end
    repeat (6) tick();
    chk("bounce_ignored", bus.o_field, 2'd0);
    bus.i_btn_mode = 1'b1;
    // Press pulse lands after the 7th edge; the state changes on the 8th
    repeat (7) tick();
    chk("press_latency_early", bus.o_field, 2'd0);
    tick();
    chk("press_latency_on_time", bus.o_field, 2'd1);
    chk("blink_first_half", bus.o_blink, 1'b1);
    repeat (7) tick();
    chk("blink_end_first_half", bus.o_blink, 1'b1);
    tick();
    chk("blink_second_half", bus.o_blink, 1'b0);
    repeat (4) tick();
    bus.i_btn_mode = 1'b0;
    repeat (12) tick();
    chk("held_single_pulse", bus.o_field, 2'd1);
    chk("captured_hh", bus.o_hh, 8'h07);

    // Simultaneous MODE and INC: mode wins, hours untouched
    bus.i_btn_mode = 1'b1;
    bus.i_btn_inc  = 1'b1;
    repeat (10) tick();
    bus.i_btn_mode = 1'b0;
    bus.i_btn_inc  = 1'b0;
    repeat (10) tick();
    chk("simul_field", bus.o_field, 2'd2);
    chk("simul_hh", bus.o_hh, 8'h07);
    press_mode();
    exp_q.push_back('{8'h07, 8'h15, 8'h30, 1'b1});
    press_mode();
    chk("simul_commit_field", bus.o_field, 2'd0);

    // Reset mid-edit
    set_cur(8'h04, 8'h20, 8'h00, 1'b0);
    press_mode();
    press_inc();
    press_mode();
    press_inc();
    chk("pre_rst_field", bus.o_field, 2'd2);
    chk("pre_rst_mm", bus.o_mm, 8'h21);
    loads_before = load_count;
    i_rst = 1'b1;
    #1;
    chk("midrst_setting", bus.o_setting, 1'b0);
    chk("midrst_blink", bus.o_blink, 1'b0);
    chk("midrst_field", bus.o_field, 2'd0);
    chk("midrst_hh", bus.o_hh, 8'h12);
    chk("midrst_mm", bus.o_mm, 8'h00);
    chk("midrst_load", bus.o_load, 1'b0);
    repeat (3) tick();
    i_rst = 1'b0;
    repeat (30) tick();
    chk("midrst_no_load", load_count, loads_before);
    chk("midrst_still_run", bus.o_field, 2'd0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
